multipattern_src: RTL and testbench
===================================

MULTIPATTERN_SRC -- requirements
Module: multipattern_src

Interface
REQ-001 SHALL have parameter BITS_PER_COLOR, default 8, meaning bits per colour component.
REQ-002 SHALL have parameter HW, default 12, meaning width of the position counters and of i_width/i_height.
REQ-003 SHALL have parameter BOX, default 64, meaning side in pixels of the mode-5 moving box.
REQ-004 SHALL have port i_pixclk  in  1  pixel clock, the only clock.
REQ-005 SHALL have port i_reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_width  in  HW  active pixels per line.
REQ-007 SHALL have port i_height  in  HW  active lines per frame.
REQ-008 SHALL have port i_mode  in  3  pattern select.
REQ-009 SHALL have port i_rd  in  1  sink consumed current pixel.
REQ-010 SHALL have port i_newline  in  1  start of next line.
REQ-011 SHALL have port i_newframe  in  1  start of next frame.
REQ-012 SHALL have port o_pixel  out  3*BITS_PER_COLOR  {red,grn,blu} for current position.
REQ-013 SHALL have port o_frame  out  8  frame counter.

Function
REQ-014 SHALL keep registered x, y; each i_rd: x+1, saturating at i_width-1.
REQ-015 SHALL on i_newline: x=0, y+1 saturating at i_height-1; i_newline beats a simultaneous i_rd.
REQ-016 SHALL on i_newframe: x=0, y=0, o_frame+1 (255 wraps to 0); beats simultaneous i_newline/i_rd.
REQ-017 SHALL latch i_mode only on i_newframe; mid-frame i_mode changes have no effect.
REQ-018 SHALL present o_pixel registered, reflecting the current (x,y) the cycle after any counter update (one-cycle latency from i_rd/i_newline/i_newframe).
REQ-019 SHALL in mode 0 output 8 colour bars (white, yellow, cyan, green, magenta, red, blue, black), each i_width>>3 pixels wide via bar-width counter, no divider; remainder pixels black.
REQ-020 SHALL in mode 1 output a checkerboard: white when x[5]^y[5], else black.
REQ-021 SHALL in mode 2 output grey = x[BITS_PER_COLOR-1:0]; mode 3 grey = y[BITS_PER_COLOR-1:0] (truncation, wraps).
REQ-022 SHALL in mode 4 output full white; modes 6-7 black.
REQ-023 SHALL in mode 5 output a white BOX x BOX square on black; top-left moves +1/-1 in x and y per i_newframe, direction reversing when the box edge reaches 0 or i_width/i_height; if i_width or i_height < BOX, the box stays at 0.
REQ-024 SHALL output black for any position with x >= i_width or y >= i_height.

Reset
REQ-025 SHALL on i_reset: x=0, y=0, o_frame=0, latched mode=0, box at (0,0) moving +x,+y, o_pixel=0.
REQ-026 SHALL give i_reset priority over every strobe; reset mid-frame resumes at mode 0, position (0,0) without requiring i_newframe.

Configuration
REQ-027 SHALL with PATTERN_BORDER_EN defined, override every mode with white at x=0, x=i_width-1, y=0 or y=i_height-1.
REQ-028 SHALL without PATTERN_BORDER_EN, apply no border; pattern output per REQ-019..024 only.

Structure
REQ-029 SHALL place mode constants (MODE_BARS..MODE_BOX) and the 8-entry bar colour table in package pattern_pkg.
REQ-030 SHALL implement the box position/direction tracker as sub-module bounce_ctr, one instance per axis.

Verification
REQ-031 SHALL verify: reset, mode 0, width 640, 80 i_rd -> o_pixel 0xFFFFFF for x 0..79, 0xFFFF00 at x=80.
REQ-032 SHALL verify: mode 1, y=0, x=31 -> 0x000000; x=32 -> 0xFFFFFF; y=32, x=32 -> 0x000000.
REQ-033 SHALL verify: i_mode 0->4 mid-frame -> bars continue; after i_newframe o_pixel 0xFFFFFF, o_frame incremented.
REQ-034 SHALL verify: i_newline+i_newframe+i_rd same cycle -> x=0, y=0, o_frame+1; 700 i_rd on width 640 -> o_pixel 0 beyond, x held 639.
REQ-035 SHALL verify: mode 5, 640x480, 576 frames -> box left edge 576, direction reverses, next frame 575; with PATTERN_BORDER_EN, x=0 in mode 6 -> 0xFFFFFF.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared constants for the multi-pattern video source:
// pattern select codes and the colour-bar table.
package pattern_pkg;

  localparam logic [2:0] MODE_BARS  = 3'd0;
  localparam logic [2:0] MODE_CHECK = 3'd1;
  localparam logic [2:0] MODE_GREYX = 3'd2;
  localparam logic [2:0] MODE_GREYY = 3'd3;
  localparam logic [2:0] MODE_WHITE = 3'd4;
  localparam logic [2:0] MODE_BOX   = 3'd5;

  // {r,g,b} on/off per bar, left to right
  localparam logic [2:0] BAR_RGB [8] = '{
    3'b111, 3'b110, 3'b011, 3'b010,
    3'b101, 3'b100, 3'b001, 3'b000
  };

endpackage

// File: rtl/bounce_ctr.sv
// One axis of the moving box: position plus direction,
// stepping once per frame and bouncing between 0 and limit.
module bounce_ctr
  import pattern_pkg::*;
#(
  parameter int W   = 12,
  parameter int BOX = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         step_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] pos_nxt_o
);

  localparam logic [W:0] BOXW = (W+1)'(BOX);

  logic [W-1:0] pos_q, pos_d;
  logic         up_q, up_d;
  logic [W:0]   hi_end;
  logic [W:0]   lim;

  assign hi_end = {1'b0, pos_q} + BOXW;
  assign lim    = {1'b0, limit_i};

  always_comb begin
    pos_d = pos_q;
    up_d  = up_q;
    if (step_i) begin
      if (lim < BOXW) begin
        pos_d = '0;
        up_d  = 1'b1;
      end else if (up_q) begin
        if (hi_end < lim) begin
          pos_d = pos_q + W'(1);
          if (hi_end + (W+1)'(1) == lim)
            up_d = 1'b0;
        end else begin
          up_d = 1'b0;
        end
      end else begin
        if (pos_q != '0) begin
          pos_d = pos_q - W'(1);
          if (pos_q == W'(1))
            up_d = 1'b1;
        end else begin
          up_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q <= '0;
      up_q  <= 1'b1;
    end else begin
      pos_q <= pos_d;
      up_q  <= up_d;
    end
  end

  assign pos_nxt_o = pos_d;

endmodule

// File: rtl/multipattern_src.sv
// Test-pattern pixel source driven by sink strobes.
// Define PATTERN_BORDER_EN for a 1-pixel white frame border.
module multipattern_src
  import pattern_pkg::*;
#(
  parameter int BITS_PER_COLOR = 8,
  parameter int HW             = 12,
  parameter int BOX            = 64
) (
  input  logic                        i_pixclk,
  input  logic                        i_reset,
  input  logic [HW-1:0]               i_width,
  input  logic [HW-1:0]               i_height,
  input  logic [2:0]                  i_mode,
  input  logic                        i_rd,
  input  logic                        i_newline,
  input  logic                        i_newframe,
  output logic [3*BITS_PER_COLOR-1:0] o_pixel,
  output logic [7:0]                  o_frame
);

  localparam int         PW   = 3*BITS_PER_COLOR;
  localparam logic [HW:0] BOXW = (HW+1)'(BOX);

  logic [HW-1:0] x_q, x_d, y_q, y_d;
  logic [7:0]    frame_q, frame_d;
  logic [2:0]    mode_q, mode_d;
  logic [HW-1:0] bcnt_q, bcnt_d;
  logic [3:0]    bidx_q, bidx_d;
  logic [PW-1:0] pix_q, pix_d;

  logic [HW-1:0] bar_w;
  logic [HW:0]   x_p1, y_p1;
  logic [HW-1:0] bx_n, by_n;
  logic          in_rng, in_box;

  assign bar_w = i_width >> 3;
  assign x_p1  = {1'b0, x_q} + (HW+1)'(1);
  assign y_p1  = {1'b0, y_q} + (HW+1)'(1);

  function automatic logic [PW-1:0] rgb(input logic [2:0] c);
    return {{BITS_PER_COLOR{c[2]}},
            {BITS_PER_COLOR{c[1]}},
            {BITS_PER_COLOR{c[0]}}};
  endfunction

  bounce_ctr #(.W(HW), .BOX(BOX)) u_bx (
    .clk_i     (i_pixclk),
    .rst_i     (i_reset),
    .step_i    (i_newframe),
    .limit_i   (i_width),
    .pos_nxt_o (bx_n)
  );

  bounce_ctr #(.W(HW), .BOX(BOX)) u_by (
    .clk_i     (i_pixclk),
    .rst_i     (i_reset),
    .step_i    (i_newframe),
    .limit_i   (i_height),
    .pos_nxt_o (by_n)
  );

  // Bar index tracks x by counting, so no x/bar_w divider.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    frame_d = frame_q;
    mode_d  = mode_q;
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    if (i_newframe) begin
      x_d     = '0;
      y_d     = '0;
      frame_d = frame_q + 8'd1;
      mode_d  = i_mode;
      bcnt_d  = '0;
      bidx_d  = '0;
    end else if (i_newline) begin
      x_d    = '0;
      bcnt_d = '0;
      bidx_d = '0;
      if (y_p1 < {1'b0, i_height})
        y_d = y_p1[HW-1:0];
    end else if (i_rd && x_p1 < {1'b0, i_width}) begin
      x_d = x_p1[HW-1:0];
      if (!bidx_q[3]) begin
        if (bcnt_q == bar_w - HW'(1)) begin
          bcnt_d = '0;
          bidx_d = bidx_q + 4'd1;
        end else begin
          bcnt_d = bcnt_q + HW'(1);
        end
      end
    end
  end

  assign in_rng = (x_d < i_width) && (y_d < i_height);
  assign in_box = ({1'b0, x_d} >= {1'b0, bx_n})
               && ({1'b0, x_d} < {1'b0, bx_n} + BOXW)
               && ({1'b0, y_d} >= {1'b0, by_n})
               && ({1'b0, y_d} < {1'b0, by_n} + BOXW);

  // Pixel is built from next-state so it lines up with x_q/y_q.
  always_comb begin
    pix_d = '0;
    if (in_rng) begin
      case (mode_d)
        MODE_BARS:
          if (bar_w != '0 && !bidx_d[3])
            pix_d = rgb(BAR_RGB[bidx_d[2:0]]);
        MODE_CHECK:
          if (x_d[5] ^ y_d[5]) pix_d = '1;
        MODE_GREYX:
          pix_d = {3{x_d[BITS_PER_COLOR-1:0]}};
        MODE_GREYY:
          pix_d = {3{y_d[BITS_PER_COLOR-1:0]}};
        MODE_WHITE:
          pix_d = '1;
        MODE_BOX:
          if (in_box) pix_d = '1;
        default:
          pix_d = '0;
      endcase
`ifdef PATTERN_BORDER_EN
      if (x_d == '0 || y_d == '0 ||
          x_d == i_width - HW'(1) ||
          y_d == i_height - HW'(1))
        pix_d = '1;
`endif
    end
  end

  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
      mode_q  <= MODE_BARS;
      bcnt_q  <= '0;
      bidx_q  <= '0;
      pix_q   <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      mode_q  <= mode_d;
      bcnt_q  <= bcnt_d;
      bidx_q  <= bidx_d;
      pix_q   <= pix_d;
    end
  end

  assign o_pixel = pix_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_multipattern_src.sv
// Randomized and directed checks of multipattern_src
// against a behavioural pixel model.
module tb_multipattern_src;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0, nl = 1'b0, nf = 1'b0;
  logic [11:0] w = 12'd640, h = 12'd480;
  logic [2:0]  md = 3'd0;
  logic [23:0] pix;
  logic [7:0]  frm;

  int n_tests = 0;
  int n_fail  = 0;

  int mx, my, mf, mm, bx, by;
  bit bux, buy, m_rst;

  int bars [8] = '{32'hFFFFFF, 32'hFFFF00, 32'h00FFFF,
                   32'h00FF00, 32'hFF00FF, 32'hFF0000,
                   32'h0000FF, 32'h000000};

  always #5 clk = ~clk;

  multipattern_src dut (
    .i_pixclk   (clk),
    .i_reset    (rst),
    .i_width    (w),
    .i_height   (h),
    .i_mode     (md),
    .i_rd       (rd),
    .i_newline  (nl),
    .i_newframe (nf),
    .o_pixel    (pix),
    .o_frame    (frm)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (x=%0d y=%0d)",
               tag, got, exp, mx, my);
    end
  endtask

  task automatic bounce(inout int p, inout bit up,
                        input int lim);
    if (lim < 64) begin
      p = 0; up = 1;
    end else if (up) begin
      if (p + 64 < lim) begin
        p++;
        if (p + 64 == lim) up = 0;
      end else up = 0;
    end else begin
      if (p > 0) begin
        p--;
        if (p == 0) up = 1;
      end else up = 1;
    end
  endtask

  function automatic int exp_pix();
    int wi, hi, bw, g;
    wi = int'(w);
    hi = int'(h);
    if (mx >= wi || my >= hi) return 0;
`ifdef PATTERN_BORDER_EN
    if (mx == 0 || my == 0 || mx == wi-1 || my == hi-1)
      return 32'hFFFFFF;
`endif
    case (mm)
      0: begin
        bw = wi / 8;
        if (bw == 0 || mx / bw >= 8) return 0;
        return bars[mx / bw];
      end
      1: return ((mx/32 + my/32) % 2) ? 32'hFFFFFF : 0;
      2: begin g = mx % 256; return g * 32'h010101; end
      3: begin g = my % 256; return g * 32'h010101; end
      4: return 32'hFFFFFF;
      5: return (mx >= bx && mx < bx+64 &&
                 my >= by && my < by+64) ? 32'hFFFFFF : 0;
      default: return 0;
    endcase
  endfunction

  task automatic cyc(input bit r, input bit a,
                     input bit l, input bit f);
    rst = r; rd = a; nl = l; nf = f;
    @(posedge clk);
    if (r) begin
      mx = 0; my = 0; mf = 0; mm = 0;
      bx = 0; by = 0; bux = 1; buy = 1; m_rst = 1;
    end else begin
      m_rst = 0;
      if (f) begin
        mx = 0; my = 0; mf = (mf + 1) % 256; mm = int'(md);
        bounce(bx, bux, int'(w));
        bounce(by, buy, int'(h));
      end else if (l) begin
        mx = 0;
        if (my + 1 < int'(h)) my++;
      end else if (a) begin
        if (mx + 1 < int'(w)) mx++;
      end
    end
    @(negedge clk);
    chk("pix", {8'h0, pix}, m_rst ? 0 : exp_pix());
    chk("frame", {24'h0, frm}, mf);
    rst = 0; rd = 0; nl = 0; nf = 0;
  endtask

  task automatic rds(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0);
  endtask

  task automatic nls(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0);
  endtask

  initial begin
    @(negedge clk);
    // reset state, bars
    w = 12'd640; h = 12'd480; md = 3'd0;
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 1);
    chk("rst_pix", {8'h0, pix}, 32'h0);
    chk("rst_frame", {24'h0, frm}, 32'h0);
    cyc(0, 0, 0, 0);
    chk("bar_x0", {8'h0, pix}, 32'hFFFFFF);
    rds(79);
    chk("bar_x79", {8'h0, pix}, 32'hFFFFFF);
    rds(1);
    chk("bar_x80", {8'h0, pix}, 32'hFFFF00);

    // mode change mid-frame ignored until newframe
    md = 3'd4;
    rds(1);
    chk("midmode", {8'h0, pix}, 32'hFFFF00);
    cyc(0, 0, 0, 1);
    chk("mode4", {8'h0, pix}, 32'hFFFFFF);
    chk("frame1", {24'h0, frm}, 32'd1);

    // checkerboard
    md = 3'd1;
    cyc(0, 0, 0, 1);
    rds(31);
    chk("chk_31_0", {8'h0, pix}, 32'h0);
    rds(1);
    chk("chk_32_0", {8'h0, pix}, 32'hFFFFFF);
    nls(32);
    rds(32);
    chk("chk_32_32", {8'h0, pix}, 32'h0);

    // simultaneous strobes, x saturation
    md = 3'd2;
    rds(5); nls(3);
    cyc(0, 1, 1, 1);
    chk("sim_pix", {8'h0, pix}, 32'h0);
    chk("sim_frame", {24'h0, frm}, 32'd3);
    rds(700);
    chk("sat_grey", {8'h0, pix}, 32'h7F7F7F);
    md = 3'd0;
    cyc(0, 0, 0, 1);
    rds(700);
    chk("sat_bars", {8'h0, pix}, 32'h0);

    // border / black modes
    md = 3'd6;
    cyc(0, 0, 0, 1);
`ifdef PATTERN_BORDER_EN
    chk("border", {8'h0, pix}, 32'hFFFFFF);
`else
    chk("border", {8'h0, pix}, 32'h0);
`endif
    rds(10); nls(10);
    chk("mode6", {8'h0, pix}, 32'h0);

    // moving box bounce at right edge
    md = 3'd5;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 576; i++) cyc(0, 0, 0, 1);
    nls(256);
    rds(575);
    chk("box_575", {8'h0, pix}, 32'h0);
    rds(1);
    chk("box_576", {8'h0, pix}, 32'hFFFFFF);
    cyc(0, 0, 0, 1);
    nls(256);
    rds(574);
    chk("box2_574", {8'h0, pix}, 32'h0);
    rds(1);
    chk("box2_575", {8'h0, pix}, 32'hFFFFFF);
    rds(63);
    chk("box2_638", {8'h0, pix}, 32'hFFFFFF);
    rds(1);
    chk("box2_639", {8'h0, pix}, 32'h0);

    // randomized traffic incl. mid-frame resets
    for (int s = 0; s < 5; s++) begin
      w = 12'($urandom_range(40, 200));
      h = 12'($urandom_range(20, 120));
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 1500; i++) begin
        md = 3'($urandom_range(0, 7));
        cyc($urandom_range(0, 999) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 99) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
